// File: rtl/seg7_display_ctrl_pkg.sv
// Shared constants for the seven-segment display controller: register map,
// CTRL bit positions and the "all off" output patterns.
package seg7_pkg;

    // Register offsets, selected by addr[3:2]
    localparam logic [1:0] REG_DIGITS = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_RAWPAT = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // CTRL bit positions
    localparam int CTRL_EN        = 0;
    localparam int CTRL_RAW       = 1;
    localparam int CTRL_BLANK_LSB = 4;

    // Active-low "nothing lit" patterns
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    typedef struct packed {
        logic [3:0] blank;
        logic       raw;
        logic       en;
    } ctrl_t;

endpackage

// File: rtl/seg7_display_ctrl_if.sv
// Peripheral-port bus from the MEM-stage memory wrapper.
// Handshake: no valid/ready; MemoryWr is a one-cycle store strobe sampled at
// the rising edge, MemoryRd qualifies a purely combinational data_out that is
// 32'h0 whenever there is no read hit.
interface seg7_display_ctrl_if;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        MemoryWr;
    logic        MemoryRd;

    modport master (output addr, output data_in, output MemoryWr, output MemoryRd,
                    input data_out);
    modport slave  (input addr, input data_in, input MemoryWr, input MemoryRd,
                    output data_out);
endinterface

// File: rtl/seg7_display_ctrl_hex_to_seg7.sv
// Hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module hex_to_seg7 (
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    // Fixed glyph table
    always_comb begin
        seg = 7'h7F;
        case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end
endmodule

// File: rtl/seg7_display_ctrl.sv
// Memory-mapped four-digit seven-segment controller with a prescaled digit
// scan, per-digit blanking and a raw segment/anode bypass.
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0010,
    parameter int          SCAN_DIV  = 100000,
    parameter int          FRAME_W   = 16
) (
    input  logic                  sysclk,
    input  logic                  rst,
    seg7_display_ctrl_if.slave    bus,
    output logic [6:0]            led,
    output logic [3:0]            an
);
    localparam int              PCNT_W   = $clog2(SCAN_DIV);
    localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(SCAN_DIV - 1);

    logic [15:0]        digits;
    ctrl_t              ctrl;
    logic [6:0]         raw_seg;
    logic [3:0]         raw_an;
    logic [PCNT_W-1:0]  pcnt;
    logic [1:0]         idx;
    logic [FRAME_W-1:0] frame_cnt;
    logic               hit;
    logic               wr_en;
    logic               tick;
    logic [1:0]         sel;
    logic [3:0]         cur_nib;
    logic [6:0]         cur_seg;
    logic [15:0]        frame16;
    logic               unused_bits;

    assign hit         = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign sel         = bus.addr[3:2];
    assign wr_en       = hit & bus.MemoryWr;
    assign tick        = (pcnt == PCNT_MAX);
    assign cur_nib     = digits[{idx, 2'b00} +: 4];
    assign frame16     = 16'(frame_cnt);
    assign unused_bits = ^{bus.addr[1:0], bus.data_in[31:16]};

    hex_to_seg7 u_hex (
        .hex (cur_nib),
        .seg (cur_seg)
    );

    // Software-visible registers; reset wins over a same-cycle store
    always_ff @(posedge sysclk) begin
        if (!rst) begin
            digits  <= '0;
            ctrl    <= '0;
            raw_seg <= '0;
            raw_an  <= '0;
        end else if (wr_en) begin
            case (sel)
                REG_DIGITS: digits <= bus.data_in[15:0];
                REG_CTRL: begin
                    ctrl.en    <= bus.data_in[CTRL_EN];
                    ctrl.raw   <= bus.data_in[CTRL_RAW];
                    ctrl.blank <= bus.data_in[CTRL_BLANK_LSB +: 4];
                end
                REG_RAWPAT: begin
                    raw_seg <= bus.data_in[6:0];
                    raw_an  <= bus.data_in[11:8];
                end
                default: ;
            endcase
        end
    end

    // Prescaler, digit index and frame counter; disabled scan parks on digit 0
    always_ff @(posedge sysclk) begin
        if (!rst) begin
            pcnt      <= '0;
            idx       <= '0;
            frame_cnt <= '0;
        end else if (!ctrl.en) begin
            pcnt <= '0;
            idx  <= '0;
        end else if (tick) begin
            pcnt <= '0;
            idx  <= idx + 2'd1;
            if (idx == 2'd3) frame_cnt <= frame_cnt + 1'b1;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    // Combinational read mux; a same-cycle store is not yet visible here
    always_comb begin
        bus.data_out = 32'h0;
        if (bus.MemoryRd && hit) begin
            case (sel)
                REG_DIGITS: bus.data_out = {16'h0, digits};
                REG_CTRL:   bus.data_out = {24'h0, ctrl.blank, 2'b00, ctrl.raw, ctrl.en};
                REG_RAWPAT: bus.data_out = {20'h0, raw_an, 1'b0, raw_seg};
                REG_STATUS: bus.data_out = {frame16, 14'h0, idx};
                default:    bus.data_out = 32'h0;
            endcase
        end
    end

    // Registered pin drive; one anode at most is low in scan mode
    always_ff @(posedge sysclk) begin
        if (!rst) begin
            an  <= AN_OFF;
            led <= SEG_BLANK;
        end else if (!ctrl.en) begin
            an  <= AN_OFF;
            led <= SEG_BLANK;
        end else if (ctrl.raw) begin
            an  <= raw_an;
            led <= raw_seg;
        end else if (ctrl.blank[idx]) begin
            an  <= AN_OFF;
            led <= SEG_BLANK;
        end else begin
            an  <= ~(4'b0001 << idx);
            led <= cur_seg;
        end
    end

endmodule
